lemming_dig_arbiter: RTL and testbench

Shares a single shovel among N lemming walker FSMs so only one lemming digs at a time. Requests are arbitrated round-robin. The arbiter offers the shovel by pulsing that lemming's `dig` input, then holds the shovel until the lemming's `digging` status drops (it has dug through and started falling). A dig budget limits total digs until it is refilled. The block sits between the level-control logic and the per-lemming FSMs; each FSM's `dig` input is driven from `dig_gnt`.

---
 rtl/lemming_pkg.sv | 28 ++
 rtl/lemming_rr_pick.sv | 34 +++
 rtl/lemming_dig_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_lemming_dig_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lemming_pkg.sv
// lemming_pkg: shared types for the lemming level logic.
//   dig_arb_state_t : shovel arbiter states (IDLE, OFFER, DIGGING)
//   lemming_walk_t  : lemming walker FSM state encodings, used by benches
//   sat_inc16       : 16-bit saturating increment for event counters
package lemming_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OFFER   = 2'd1,
    DIGGING = 2'd2
  } dig_arb_state_t;

  typedef enum logic [2:0] {
    WL    = 3'd0,
    WR    = 3'd1,
    FALLL = 3'd2,
    FALLR = 3'd3,
    DIGL  = 3'd4,
    DIGR  = 3'd5
  } lemming_walk_t;

  localparam int STATS_W = 16;

  function automatic logic [STATS_W-1:0] sat_inc16(input logic [STATS_W-1:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/lemming_rr_pick.sv
// lemming_rr_pick: combinational round-robin picker.
// Ports:
//   req   [N]          request vector
//   ptr   [$clog2(N)]  index with highest priority this round
//   idx   [$clog2(N)]  first requesting index at or after ptr, wrapping
//   valid              any request present
module lemming_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int OW = $clog2(N);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int               cand;
    logic [OW-1:0]    cand_idx;
    cand     = 0;
    cand_idx = {OW{1'b0}};
    valid    = 1'b0;
    idx      = {OW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      cand     = (int'(ptr) + i) % N;
      cand_idx = OW'(cand);
      valid    = valid | req[cand_idx];
      idx      = req[cand_idx] ? cand_idx : idx;
    end
  end

endmodule

// File: rtl/lemming_dig_arbiter.sv
// lemming_dig_arbiter: shares one shovel among N lemming walker FSMs.
// A requester is picked round-robin, offered the shovel by a one-hot pulse on
// dig_gnt, and keeps it until its digging status drops. Each accepted offer
// consumes one unit of a refillable dig budget.
// Ports:
//   clk, areset (async, active-high)
//   dig_req [N]      per-lemming dig request (level)
//   digging [N]      per-lemming digging status
//   refill           reload budget to BUDGET (wins over a same-cycle decrement)
//   dig_gnt [N]      one-hot offer, drives each lemming FSM's dig input
//   busy             shovel offered or in use
//   owner            current or last shovel holder
//   budget_left      digs remaining
//   exhausted        budget_left == 0
// Optional (macro LEMMING_DIG_ARB_STATS_EN):
//   grant_count [16]   saturating count of accepted offers
//   timeout_count [16] saturating count of withdrawn offers
module lemming_dig_arbiter
  import lemming_pkg::*;
#(
  parameter int N           = 4,
  parameter int BUDGET      = 8,
  parameter int ACK_TIMEOUT = 3
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic [N-1:0]                  dig_req,
  input  logic [N-1:0]                  digging,
  input  logic                          refill,
  output logic [N-1:0]                  dig_gnt,
  output logic                          busy,
  output logic [$clog2(N)-1:0]          owner,
  output logic [$clog2(BUDGET+1)-1:0]   budget_left,
  output logic                          exhausted
`ifdef LEMMING_DIG_ARB_STATS_EN
  ,
  output logic [15:0]                   grant_count,
  output logic [15:0]                   timeout_count
`endif
);

  localparam int OW = $clog2(N);
  localparam int BW = $clog2(BUDGET + 1);
  localparam int TW = $clog2(ACK_TIMEOUT);

  localparam logic [BW-1:0] BUDGET_FULL = BW'(BUDGET);
  localparam logic [TW-1:0] TMR_LAST    = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE     = TW'(1);
  localparam logic [OW-1:0] OWN_LAST    = OW'(N - 1);
  localparam logic [OW-1:0] OWN_ONE     = OW'(1);

  dig_arb_state_t state_r, state_nxt;
  logic [OW-1:0]  ptr_r, ptr_nxt;
  logic [OW-1:0]  owner_r, owner_nxt;
  logic [TW-1:0]  tmr_r, tmr_nxt;
  logic [BW-1:0]  budget_r, budget_nxt;
  logic [OW-1:0]  ptr_adv_s;
  logic [OW-1:0]  pick_idx_s;
  logic           pick_vld_s;
  logic           take_s;
  logic           withdraw_s;

  lemming_rr_pick #(.N(N)) u_pick (
    .req   (dig_req),
    .ptr   (ptr_r),
    .idx   (pick_idx_s),
    .valid (pick_vld_s)
  );

  // Priority moves just past the owner whether its offer was taken or withdrawn.
  assign ptr_adv_s = (owner_r == OWN_LAST) ? {OW{1'b0}} : (owner_r + OWN_ONE);

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state and datapath-update decode.
  always_comb begin
    state_nxt  = state_r;
    ptr_nxt    = ptr_r;
    owner_nxt  = owner_r;
    tmr_nxt    = tmr_r;
    take_s     = 1'b0;
    withdraw_s = 1'b0;
    case (state_r)
      IDLE: begin
        if ((budget_r != {BW{1'b0}}) && pick_vld_s) begin
          owner_nxt = pick_idx_s;
          tmr_nxt   = {TW{1'b0}};
          state_nxt = OFFER;
        end else begin
          state_nxt = IDLE;
        end
      end
      OFFER: begin
        if (digging[owner_r]) begin
          state_nxt = DIGGING;
          take_s    = 1'b1;
          ptr_nxt   = ptr_adv_s;
        end else if (tmr_r == TMR_LAST) begin
          // Lemming was falling or not walking: withdraw without charging.
          state_nxt  = IDLE;
          withdraw_s = 1'b1;
          ptr_nxt    = ptr_adv_s;
        end else begin
          tmr_nxt = tmr_r + TMR_ONE;
        end
      end
      DIGGING: begin
        if (!digging[owner_r]) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DIGGING;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Budget update: refill beats a same-cycle decrement; decrement saturates at 0.
  always_comb begin
    budget_nxt = budget_r;
    if (refill) begin
      budget_nxt = BUDGET_FULL;
    end else if (take_s && (budget_r != {BW{1'b0}})) begin
      budget_nxt = budget_r - {{(BW-1){1'b0}}, 1'b1};
    end else begin
      budget_nxt = budget_r;
    end
  end

  // Pointer, owner, timer and budget registers.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ptr_r    <= {OW{1'b0}};
      owner_r  <= {OW{1'b0}};
      tmr_r    <= {TW{1'b0}};
      budget_r <= BUDGET_FULL;
    end else begin
      ptr_r    <= ptr_nxt;
      owner_r  <= owner_nxt;
      tmr_r    <= tmr_nxt;
      budget_r <= budget_nxt;
    end
  end

  // Moore outputs decoded from registers only.
  always_comb begin
    dig_gnt = {N{1'b0}};
    if (state_r == OFFER) begin
      dig_gnt[owner_r] = 1'b1;
    end else begin
      dig_gnt = {N{1'b0}};
    end
    busy      = (state_r != IDLE);
    exhausted = (budget_r == {BW{1'b0}});
  end

  assign owner       = owner_r;
  assign budget_left = budget_r;

`ifdef LEMMING_DIG_ARB_STATS_EN
  logic [STATS_W-1:0] grant_cnt_r;
  logic [STATS_W-1:0] timeout_cnt_r;

  // Event counters; only areset clears them.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      grant_cnt_r   <= 16'd0;
      timeout_cnt_r <= 16'd0;
    end else begin
      grant_cnt_r   <= take_s     ? sat_inc16(grant_cnt_r)   : grant_cnt_r;
      timeout_cnt_r <= withdraw_s ? sat_inc16(timeout_cnt_r) : timeout_cnt_r;
    end
  end

  assign grant_count   = grant_cnt_r;
  assign timeout_count = timeout_cnt_r;
`endif

endmodule

// File: tb/tb_lemming_dig_arbiter.sv
module tb_lemming_dig_arbiter;
  import lemming_pkg::*;

  localparam int N           = 4;
  localparam int BUDGET      = 8;
  localparam int ACK_TIMEOUT = 3;

  logic                        clk = 1'b0;
  logic                        areset;
  logic [N-1:0]                dig_req;
  logic [N-1:0]                digging;
  logic                        refill;
  logic [N-1:0]                dig_gnt;
  logic                        busy;
  logic [$clog2(N)-1:0]        owner;
  logic [$clog2(BUDGET+1)-1:0] budget_left;
  logic                        exhausted;
`ifdef LEMMING_DIG_ARB_STATS_EN
  logic [15:0]                 grant_count;
  logic [15:0]                 timeout_count;
`endif

  lemming_dig_arbiter #(.N(N), .BUDGET(BUDGET), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk         (clk),
    .areset      (areset),
    .dig_req     (dig_req),
    .digging     (digging),
    .refill      (refill),
    .dig_gnt     (dig_gnt),
    .busy        (busy),
    .owner       (owner),
    .budget_left (budget_left),
    .exhausted   (exhausted)
`ifdef LEMMING_DIG_ARB_STATS_EN
    ,
    .grant_count   (grant_count),
    .timeout_count (timeout_count)
`endif
  );

  always #5 clk = ~clk;

  int            n_tests = 0;
  int            n_fail  = 0;
  lemming_walk_t lw [N];
  int            dig_left [N];
  int            dig_len = 2;
  int            mptr = 0;
  int            mbudget = BUDGET;
  int            m_grants = 0;
  int            m_tmo = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester at or after p, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  // One clock; lemmings react to the dig offer present before the edge.
  task automatic tick();
    logic [N-1:0] g;
    g = dig_gnt;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (lw[i] == DIGL) begin
        dig_left[i]--;
        if (dig_left[i] <= 0) lw[i] = WL;
      end else if (lw[i] == WL && g[i]) begin
        lw[i] = DIGL;
        dig_left[i] = dig_len;
      end
      digging[i] = (lw[i] == DIGL);
    end
  endtask

  task automatic lemmings_home();
    for (int i = 0; i < N; i++) begin
      lw[i] = WL;
      dig_left[i] = 0;
    end
    digging = '0;
  endtask

  // One request round, checked against the arbitration rules.
  task automatic txn(input logic [N-1:0] req, input int len, input bit refill_on_ack);
    int           exp_own;
    int           gcnt;
    int           dcnt;
    bit           acked;
    logic [N-1:0] oh;
    dig_len = len;
    exp_own = rr_pick(req, mptr);
    dig_req = req;
    tick();
    if (mbudget == 0) begin
      for (int k = 0; k < 3; k++) begin
        chk("exhausted_no_gnt", dig_gnt, '0);
        chk("exhausted_idle", busy, 0);
        tick();
      end
      dig_req = '0;
      return;
    end
    oh = '0;
    oh[exp_own] = 1'b1;
    chk("grant_onehot", dig_gnt, oh);
    chk("grant_owner", owner, exp_own);
    chk("grant_busy", busy, 1);
    dig_req = '0;
    acked = (lw[exp_own] == WL);
    gcnt = 1;
    for (int k = 0; k < 12 && dig_gnt != '0; k++) begin
      refill = refill_on_ack && (gcnt == 2);
      tick();
      refill = 1'b0;
      if (dig_gnt != '0) begin
        gcnt++;
        chk("grant_held", dig_gnt, oh);
      end
    end
    chk("offer_len", gcnt, acked ? 2 : ACK_TIMEOUT);
    if (refill_on_ack) mbudget = BUDGET;
    else if (acked && mbudget > 0) mbudget--;
    if (acked) begin
      m_grants++;
      chk("digging_busy", busy, 1);
      chk("budget_after_take", budget_left, mbudget);
      dcnt = 1;
      for (int k = 0; k < 20 && busy; k++) begin
        tick();
        if (busy) dcnt++;
      end
      chk("dig_hold_len", dcnt, len);
    end else begin
      m_tmo++;
      chk("timeout_idle", busy, 0);
    end
    mptr = (exp_own + 1) % N;
    chk("budget_left", budget_left, mbudget);
    chk("exhausted_flag", exhausted, (mbudget == 0));
    chk("released_gnt", dig_gnt, '0);
  endtask

  task automatic pulse_refill();
    refill = 1'b1;
    tick();
    refill = 1'b0;
    mbudget = BUDGET;
    chk("refill_budget", budget_left, BUDGET);
    chk("refill_not_exhausted", exhausted, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] rq;
    areset = 1'b1;
    dig_req = '0;
    refill = 1'b0;
    lemmings_home();
    #3;
    chk("rst_gnt", dig_gnt, '0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_exhausted", exhausted, 0);
    chk("rst_budget", budget_left, BUDGET);
    tick();
    tick();
    areset = 1'b0;
    tick();

    // Single request from lemming 2.
    txn(4'b0100, 2, 1'b0);
    chk("first_budget", budget_left, BUDGET - 1);

    // All requesting: rotation continues from just past lemming 2.
    for (int k = 0; k < 5; k++) txn(4'b1111, 1 + k % 3, 1'b0);

    // Lemming 1 falling: offer withdrawn, no charge, priority moves past it.
    lw[1] = FALLL;
    txn(4'b0010, 2, 1'b0);
    lw[1] = WL;
    txn(4'b1111, 1, 1'b0);

    // Drain the budget, then requests must be ignored until refill.
    for (int k = 0; k < BUDGET + 2 && mbudget > 0; k++) txn(4'b1111, 1, 1'b0);
    chk("drained", budget_left, 0);
    txn(4'b1111, 1, 1'b0);
    pulse_refill();
    txn(4'b0001, 1, 1'b0);

    // Refill in the same cycle as the accepted offer.
    txn(4'b1010, 2, 1'b1);
    chk("refill_wins", budget_left, BUDGET);

    // Randomized rounds.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++) lw[i] = ($urandom_range(0, 4) == 0) ? FALLL : WL;
      rq = N'($urandom_range(1, (1 << N) - 1));
      if (mbudget == 0 && $urandom_range(0, 1) == 1) pulse_refill();
      txn(rq, $urandom_range(1, 4), ($urandom_range(0, 7) == 0));
    end
    lemmings_home();
    if (mbudget < 2) pulse_refill();

    // areset mid-OFFER: grant drops without a clock edge.
    lw[0] = FALLL;
    dig_req = 4'b0001;
    tick();
    chk("pre_rst_offer", dig_gnt, 4'b0001);
    #2;
    areset = 1'b1;
    #1;
    chk("async_rst_gnt", dig_gnt, '0);
    chk("async_rst_busy", busy, 0);
    dig_req = '0;
    lemmings_home();
    tick();
    areset = 1'b0;
    mptr = 0;
    mbudget = BUDGET;
    m_grants = 0;
    m_tmo = 0;
    tick();

    // Consume one dig, then areset mid-DIGGING.
    txn(4'b0100, 1, 1'b0);
    dig_len = 10;
    dig_req = 4'b1000;
    tick();
    tick();
    tick();
    chk("pre_rst_digging", busy, 1);
    chk("pre_rst_dig_gnt", dig_gnt, '0);
    #2;
    areset = 1'b1;
    #1;
    chk("dig_rst_busy", busy, 0);
    chk("dig_rst_gnt", dig_gnt, '0);
    chk("dig_rst_budget", budget_left, BUDGET);
    chk("dig_rst_owner", owner, 0);
    dig_req = '0;
    lemmings_home();
    tick();
    areset = 1'b0;
    mptr = 0;
    mbudget = BUDGET;
    m_grants = 0;
    m_tmo = 0;
    tick();

    // Pointer back at 0: lowest requester wins.
    txn(4'b0110, 2, 1'b0);
    chk("post_rst_owner", owner, 1);

`ifdef LEMMING_DIG_ARB_STATS_EN
    chk("grant_count", grant_count, m_grants);
    chk("timeout_count", timeout_count, m_tmo);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
